if_fetch_queue: RTL and testbench

Instruction-fetch stage directly upstream of decode, which holds the immediate generator. Owns the PC, issues in-order word reads to instruction memory and buffers returned instructions in a small FIFO. Presents {instr, pc} to decode with a valid/ready handshake. Flushes on EX-stage redirects (taken branch, JAL, JALR).

---
 rtl/if_fetch_queue.sv | 161 ++++++++++++++++
 tb/tb_if_fetch_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch queue: owns the PC, issues in-order imem word reads and
// buffers returned instructions for decode, flushing on EX-stage redirects.

module if_fetch_queue_chk #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = 2
) (
  input logic          clk,
  input logic          rst,
  input logic [CW-1:0] fifo_count,
  input logic [CW-1:0] outstanding,
  input logic [CW-1:0] discard
);
  localparam int unsigned OW = CW + 1;

  occupancy_bound: assert property (@(posedge clk) disable iff (rst)
    (OW'(fifo_count) + OW'(outstanding)) <= OW'(DEPTH));

  discard_bound: assert property (@(posedge clk) disable iff (rst)
    discard <= outstanding);
endmodule

module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = CW + 1;
  localparam logic [OW-1:0] DEPTH_OCC = OW'(DEPTH);
  localparam logic [31:0]   NOP       = 32'h0000_0013;

  logic [31:0]   fetch_pc_r;
  logic [31:0]   instr_mem_r [DEPTH];
  logic [31:0]   pc_mem_r    [DEPTH];
  logic [31:0]   pcq_mem_r   [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] pcq_rd_r;
  logic [AW-1:0] pcq_wr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] discard_r;

  logic          pop_s;
  logic          accept_s;
  logic          drop_s;
  logic          pcq_pop_s;
  logic [OW-1:0] occupancy_s;
  logic [CW-1:0] outstanding_nxt_s;

  assign imem_addr = fetch_pc_r;

  // Head presentation, request rule and response classification
  always_comb begin
    id_valid          = 1'b0;
    id_instr          = NOP;
    id_pc             = 32'h0000_0000;
    pop_s             = 1'b0;
    occupancy_s       = {OW{1'b0}};
    imem_req          = 1'b0;
    accept_s          = 1'b0;
    drop_s            = 1'b0;
    pcq_pop_s         = 1'b0;
    outstanding_nxt_s = outstanding_r;

    if (count_r != {CW{1'b0}}) begin
      id_valid = 1'b1;
      id_instr = instr_mem_r[rd_ptr_r];
      id_pc    = pc_mem_r[rd_ptr_r];
    end else begin
      id_valid = 1'b0;
    end

    pop_s       = id_valid && id_ready;
    // Slots already promised: buffered entries plus reads still in flight.
    occupancy_s = OW'(count_r) + OW'(outstanding_r) - OW'(pop_s);
    imem_req    = !rst && !redirect_valid && (occupancy_s < DEPTH_OCC);

    pcq_pop_s = imem_rvalid && (discard_r == {CW{1'b0}});
    accept_s  = pcq_pop_s && !redirect_valid;
    drop_s    = imem_rvalid && (discard_r != {CW{1'b0}});
    outstanding_nxt_s = outstanding_r + CW'(imem_req) - CW'(imem_rvalid);
  end

  // Fetch PC, queue pointers and in-flight bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      rd_ptr_r      <= {AW{1'b0}};
      wr_ptr_r      <= {AW{1'b0}};
      pcq_rd_r      <= {AW{1'b0}};
      pcq_wr_r      <= {AW{1'b0}};
      count_r       <= {CW{1'b0}};
      outstanding_r <= {CW{1'b0}};
      discard_r     <= {CW{1'b0}};
    end else if (redirect_valid) begin
      // Every read still in flight after this edge belongs to the old stream.
      fetch_pc_r    <= redirect_pc & 32'hFFFF_FFFC;
      rd_ptr_r      <= {AW{1'b0}};
      wr_ptr_r      <= {AW{1'b0}};
      pcq_rd_r      <= {AW{1'b0}};
      pcq_wr_r      <= {AW{1'b0}};
      count_r       <= {CW{1'b0}};
      outstanding_r <= outstanding_nxt_s;
      discard_r     <= outstanding_nxt_s;
    end else begin
      if (imem_req) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
        pcq_wr_r   <= pcq_wr_r + AW'(1);
      end
      if (pcq_pop_s) begin
        pcq_rd_r <= pcq_rd_r + AW'(1);
      end
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r       <= count_r + CW'(accept_s) - CW'(pop_s);
      outstanding_r <= outstanding_nxt_s;
      discard_r     <= discard_r - CW'(drop_s);
    end
  end

  // Instruction FIFO and request-PC queue storage
  always_ff @(posedge clk) begin
    if (accept_s) begin
      instr_mem_r[wr_ptr_r] <= imem_rdata;
      pc_mem_r[wr_ptr_r]    <= pcq_mem_r[pcq_rd_r];
    end
    if (imem_req) begin
      pcq_mem_r[pcq_wr_r] <= fetch_pc_r;
    end
  end

  if_fetch_queue_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .fifo_count  (count_r),
    .outstanding (outstanding_r),
    .discard     (discard_r)
  );
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed vector table, reset-in-flight sequence and
// randomized traffic checked against a queue-based reference model.
module tb_if_fetch_queue;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready = 1'b0;

  always #5 clk = ~clk;

  if_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
  );

  typedef struct { logic [31:0] addr; int due; } memreq_t;
  typedef struct { logic [31:0] addr; logic stale; } inflight_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } entry_t;
  typedef struct {
    bit rst_first; int lat;
    logic rv; logic [31:0] rpc; logic rdy;
    logic e_req; logic [31:0] e_addr; logic e_valid; logic [31:0] e_pc;
  } vec_t;

  memreq_t   memq[$];
  inflight_t m_inf[$];
  entry_t    m_fifo[$];
  logic [31:0] m_pc = RESET_PC;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 1;
  bit mem_rand = 1'b0;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_pc;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  function automatic vec_t mk(input bit rf, input int lat, input logic rv,
                              input logic [31:0] rpc, input logic rdy, input logic er,
                              input logic [31:0] ea, input logic ev, input logic [31:0] ep);
    vec_t v;
    v.rst_first = rf; v.lat = lat; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
    logic exp_valid, exp_req, pop;
    int occ;
    inflight_t f;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(memq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    @(negedge clk);
    s_req = imem_req; s_addr = imem_addr; s_valid = id_valid; s_instr = id_instr; s_pc = id_pc;

    exp_valid = (m_fifo.size() != 0);
    pop       = exp_valid && rdy;
    occ       = m_fifo.size() + m_inf.size() - (pop ? 1 : 0);
    exp_req   = !rv && (occ < DEPTH);
    chk("id_valid", {31'b0, s_valid}, {31'b0, exp_valid});
    chk("id_instr", s_instr, exp_valid ? m_fifo[0].instr : NOP);
    chk("id_pc", s_pc, exp_valid ? m_fifo[0].pc : 32'h0);
    chk("imem_req", {31'b0, s_req}, {31'b0, exp_req});
    chk("imem_addr", s_addr, m_pc);

    if (imem_rvalid) memq.delete(0);
    if (s_req) memq.push_back('{addr: s_addr,
                                due: cyc + (mem_rand ? int'($urandom_range(mem_lat, 1)) : mem_lat)});

    if (pop) m_fifo.delete(0);
    if (imem_rvalid && m_inf.size() > 0) begin
      f = m_inf[0];
      m_inf.delete(0);
      if (!f.stale && !rv) m_fifo.push_back('{instr: word_of(f.addr), pc: f.addr});
    end
    if (rv) begin
      m_fifo.delete();
      foreach (m_inf[i]) m_inf[i].stale = 1'b1;
      m_pc = {rpc[31:2], 2'b00};
    end else if (exp_req) begin
      m_inf.push_back('{addr: m_pc, stale: 1'b0});
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    redirect_valid = 1'b0;
    id_ready = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_id_instr", id_instr, NOP);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    memq.delete();
    m_fifo.delete();
    m_inf.delete();
    m_pc = RESET_PC;
  endtask

  initial begin
    vec_t tbl[$];
    // streaming, 1-cycle memory
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 32'h0,  0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 32'h4,  0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 32'h8,  1, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 32'hC,  1, 32'h4));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 32'h10, 1, 32'h8));
    // decode stalled six cycles, then drains in order
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 32'h0,  0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h4,  0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h8,  1, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h8,  1, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h8,  1, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h8,  1, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 32'h8,  1, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 32'hC,  1, 32'h4));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 32'h10, 1, 32'h8));
    // redirect with two reads in flight, 3-cycle memory
    tbl.push_back(mk(1, 3, 0, 0,            1, 1, 32'h0,   0, 32'h0));
    tbl.push_back(mk(0, 3, 0, 0,            1, 1, 32'h4,   0, 32'h0));
    tbl.push_back(mk(0, 3, 1, 32'h0000_0103, 1, 0, 32'h8,  0, 32'h0));
    tbl.push_back(mk(0, 3, 0, 0,            1, 0, 32'h100, 0, 32'h0));
    tbl.push_back(mk(0, 3, 0, 0,            1, 1, 32'h100, 0, 32'h0));
    tbl.push_back(mk(0, 3, 0, 0,            1, 1, 32'h104, 0, 32'h0));
    tbl.push_back(mk(0, 3, 0, 0,            1, 0, 32'h108, 0, 32'h0));
    tbl.push_back(mk(0, 3, 0, 0,            1, 0, 32'h108, 0, 32'h0));
    tbl.push_back(mk(0, 3, 0, 0,            1, 1, 32'h108, 1, 32'h100));
    // redirect coinciding with a response
    tbl.push_back(mk(1, 1, 0, 0,     1, 1, 32'h0,  0, 32'h0));
    tbl.push_back(mk(0, 1, 1, 32'h40, 1, 0, 32'h4,  0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0,     1, 1, 32'h40, 0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0,     1, 1, 32'h44, 0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0,     1, 1, 32'h48, 1, 32'h40));
    // PC wrap-around
    tbl.push_back(mk(1, 1, 1, 32'hFFFF_FFF8, 1, 0, 32'h0,         0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0,             1, 1, 32'hFFFF_FFF8, 0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0,             1, 1, 32'hFFFF_FFFC, 0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0,             1, 1, 32'h0,         1, 32'hFFFF_FFF8));
    tbl.push_back(mk(0, 1, 0, 0,             1, 1, 32'h4,         1, 32'hFFFF_FFFC));

    #2;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_first) begin
        mem_rand = 1'b0;
        mem_lat  = tbl[i].lat;
        do_reset(2);
      end
      cycle(tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      chk($sformatf("vec%0d_req", i), {31'b0, s_req}, {31'b0, tbl[i].e_req});
      chk($sformatf("vec%0d_addr", i), s_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_valid", i), {31'b0, s_valid}, {31'b0, tbl[i].e_valid});
      chk($sformatf("vec%0d_pc", i), s_pc, tbl[i].e_valid ? tbl[i].e_pc : 32'h0);
      chk($sformatf("vec%0d_instr", i), s_instr, tbl[i].e_valid ? word_of(tbl[i].e_pc) : NOP);
    end

    // reset while the FIFO is full, then restart at RESET_PC
    mem_rand = 1'b0;
    mem_lat  = 1;
    do_reset(2);
    repeat (4) cycle(1'b0, 32'h0, 1'b0);
    chk("full_before_rst_valid", {31'b0, s_valid}, 32'h1);
    chk("full_before_rst_pc", s_pc, RESET_PC);
    do_reset(1);
    cycle(1'b0, 32'h0, 1'b1);
    chk("after_rst_req", {31'b0, s_req}, 32'h1);
    chk("after_rst_addr", s_addr, RESET_PC);

    // randomized traffic with varying memory latency
    mem_rand = 1'b1;
    for (int seg = 0; seg < 3; seg++) begin
      mem_lat = (seg == 0) ? 1 : ((seg == 1) ? 2 : 4);
      do_reset(2);
      for (int n = 0; n < 1000; n++) begin
        logic rv, rdy;
        logic [31:0] rpc;
        rv  = ($urandom_range(99, 0) < 6);
        rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
        rdy = ($urandom_range(3, 0) != 0);
        if ($urandom_range(499, 0) == 0) do_reset(1);
        cycle(rv, rpc, rdy);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
